// File: rtl/stream_demux1_2.sv
// stream_demux1_2: registered 1:2 stream demultiplexer.
// One input beat is steered by in_sel into one of two one-entry output slots.
// Each slot has its own valid/ready handshake, so a stalled consumer never
// blocks beats headed for the other consumer.
// Optional feature macro: STREAM_DEMUX_STATS_EN adds per-output accept
// counters cnt0/cnt1 of CNT_W bits.
module stream_demux1_2 #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

  logic             slot_valid [2];
  logic [WIDTH-1:0] slot_data  [2];
  logic             slot_ready [2];
  logic             accept;

  // Reject nonsensical widths at elaboration time.
  if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("stream_demux1_2: WIDTH and CNT_W must be at least 1");
  end

  assign slot_ready[0] = out0_ready;
  assign slot_ready[1] = out1_ready;

  // Accept when the addressed slot is empty or is being drained this cycle;
  // the other slot's state plays no part, so it can never block this beat.
  assign in_ready = !reset && (!slot_valid[in_sel] || slot_ready[in_sel]);
  assign accept   = in_valid && in_ready;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_slot
    slot_state_t      state_reg;
    slot_state_t      state_next;
    logic [WIDTH-1:0] data_reg;
    logic             load;
    logic             drain;
    logic             valid_w;

    assign load  = accept && (in_sel == 1'(gi));
    assign drain = valid_w && slot_ready[gi];

    // State register: reset empties the slot and discards any held beat.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_reg <= S_EMPTY;
      end else begin
        state_reg <= state_next;
      end
    end

    // Next state: fill on load; empty only on a drain without a refill.
    always_comb begin
      state_next = state_reg;
      case (state_reg)
        S_EMPTY: if (load) state_next = S_FULL;
        S_FULL:  if (drain && !load) state_next = S_EMPTY;
        default: state_next = S_EMPTY;
      endcase
    end

    // Output decode: the slot presents a beat whenever it is full.
    always_comb begin
      valid_w = (state_reg == S_FULL);
    end

    // Payload register: written only on a load, so it is stable while stalled.
    always_ff @(posedge clk) begin
      if (reset) begin
        data_reg <= '0;
      end else if (load) begin
        data_reg <= in_data;
      end
    end

    assign slot_valid[gi] = valid_w;
    assign slot_data[gi]  = data_reg;
  end

  assign out0_valid = slot_valid[0];
  assign out0_data  = slot_data[0];
  assign out1_valid = slot_valid[1];
  assign out1_data  = slot_data[1];

`ifdef STREAM_DEMUX_STATS_EN
  logic [CNT_W-1:0] slot_cnt [2];

  for (gi = 0; gi < 2; gi++) begin : g_stats
    logic [CNT_W-1:0] cnt_reg;

    // Count accepts into this slot; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (g_slot[gi].load) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign slot_cnt[gi] = cnt_reg;
  end

  assign cnt0 = slot_cnt[0];
  assign cnt1 = slot_cnt[1];
`endif

endmodule

// File: tb/tb_stream_demux1_2.sv
// Directed testbench for stream_demux1_2. Inputs change 1 time unit after
// the rising edge; outputs are sampled 1 time unit after that.
module tb_stream_demux1_2;

  localparam int WIDTH = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out0_valid;
  logic [WIDTH-1:0] out0_data;
  logic             out0_ready;
  logic             out1_valid;
  logic [WIDTH-1:0] out1_data;
  logic             out1_ready;
`ifdef STREAM_DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
`endif

  int checks_cnt   = 0;
  int failures_cnt = 0;

  always #5 clk = ~clk;

  stream_demux1_2 #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out0_valid(out0_valid),
    .out0_data (out0_data),
    .out0_ready(out0_ready),
    .out1_valid(out1_valid),
    .out1_data (out1_data),
    .out1_ready(out1_ready)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      failures_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    tick();
    tick();
    #1;
    check("rst_out0_valid", 64'(out0_valid), 64'd0);
    check("rst_out1_valid", 64'(out1_valid), 64'd0);
    check("rst_out0_data", out0_data, 64'd0);
    check("rst_out1_data", out1_data, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);

    // Test 1: accept 0xA5 into slot 0 with consumer 0 stalled.
    reset    = 1'b0;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 64'hA5;
    #1;
    check("t1_in_ready_empty", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check("t1_out0_valid", 64'(out0_valid), 64'd1);
    check("t1_out0_data", out0_data, 64'hA5);
    check("t1_out1_valid", 64'(out1_valid), 64'd0);
    check("t1_in_ready_sel0", 64'(in_ready), 64'd0);
    in_sel  = 1'b1;
    in_data = 64'hDEAD;
    #1;
    check("t1_in_ready_sel1", 64'(in_ready), 64'd1);
    tick();
    #1;
    check("t1_idle_no_write_out1", 64'(out1_valid), 64'd0);
    check("t1_idle_out1_data", out1_data, 64'd0);

    // Test 2: hold slot 0 under backpressure, then drain.
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      check($sformatf("t2_hold%0d_data", i), out0_data, 64'hA5);
      check($sformatf("t2_hold%0d_valid", i), 64'(out0_valid), 64'd1);
    end
    out0_ready = 1'b1;
    in_sel     = 1'b0;
    #1;
    check("t2_in_ready_draining", 64'(in_ready), 64'd1);
    tick();
    out0_ready = 1'b0;
    #1;
    check("t2_empty_after_drain", 64'(out0_valid), 64'd0);

    // Backpressured out0 does not block a beat for out1.
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 64'h11;
    tick();
    in_sel   = 1'b1;
    in_data  = 64'h22;
    #1;
    check("ind_in_ready_sel1", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check("ind_out0_data", out0_data, 64'h11);
    check("ind_out1_data", out1_data, 64'h22);
    check("ind_both_valid", {62'd0, out1_valid, out0_valid}, 64'd3);
    // Both slots drain in the same cycle.
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    tick();
    #1;
    check("ind_both_drained", {62'd0, out1_valid, out0_valid}, 64'd0);

    // Test 3: stream 1..8 alternating, both consumers ready.
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_sel   = ((i % 2) == 0) ? 1'b1 : 1'b0;
      in_data  = 64'(i);
      #1;
      check($sformatf("t3_in_ready_beat%0d", i), 64'(in_ready), 64'd1);
      tick();
      #1;
      if ((i % 2) == 1) begin
        check($sformatf("t3_out0_beat%0d", i), out0_data, 64'(i));
        check($sformatf("t3_out0_valid%0d", i), 64'(out0_valid), 64'd1);
      end else begin
        check($sformatf("t3_out1_beat%0d", i), out1_data, 64'(i));
        check($sformatf("t3_out1_valid%0d", i), 64'(out1_valid), 64'd1);
      end
    end
    in_valid = 1'b0;
    tick();
    #1;
    check("t3_drained", {62'd0, out1_valid, out0_valid}, 64'd0);

    // Test 4: simultaneous drain and refill of slot 1.
    out1_ready = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b1;
    in_data    = 64'h55;
    tick();
    out1_ready = 1'b1;
    in_data    = 64'h77;
    #1;
    check("t4_in_ready", 64'(in_ready), 64'd1);
    check("t4_old_data", out1_data, 64'h55);
    tick();
    in_valid   = 1'b0;
    out1_ready = 1'b0;
    #1;
    check("t4_valid_kept", 64'(out1_valid), 64'd1);
    check("t4_new_data", out1_data, 64'h77);

    // Test 5: reset wins over a pending drain and accept.
    out0_ready = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 64'h99;
    tick();
    check("t5_pre_out0_data", out0_data, 64'h99);
    reset      = 1'b1;
    out0_ready = 1'b1;
    in_data    = 64'hBB;
    #1;
    check("t5_in_ready_in_reset", 64'(in_ready), 64'd0);
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t5_out0_valid", 64'(out0_valid), 64'd0);
    check("t5_out1_valid", 64'(out1_valid), 64'd0);
    check("t5_out0_data", out0_data, 64'd0);
    check("t5_out1_data", out1_data, 64'd0);

`ifdef STREAM_DEMUX_STATS_EN
    // Test 6: counters wrap at 2^CNT_W and ignore drains.
    check("t6_cnt0_reset", 64'(cnt0), 64'd0);
    check("t6_cnt1_reset", 64'(cnt1), 64'd0);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    in_valid   = 1'b1;
    in_sel     = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 64'(i);
      tick();
    end
    in_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 64'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    #1;
    check("t6_cnt1_wrapped", 64'(cnt1), 64'd1);
    check("t6_cnt0", 64'(cnt0), 64'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule
